// File: rtl/constraint_counter_pool_ctrl_if.sv
// ----------------------------------------------------------------------------
// constraint_counter_pool_ctrl_if
// Bundles the per-requester control and status vectors of the bounded-repetition
// counter pool.
//   en      : engine enable (0 freezes counts and allocation)
//   start   : per-requester entry pulse, claims or restarts a counter
//   inc     : per-requester repetition pulse
//   clr     : per-requester abort, releases the counter
//   owned   : requester currently holds a counter
//   out     : range match for the requester's count
//   denied  : start not granted this cycle
//   free_n  : number of idle counters
// master = NFA engine side, slave = pool controller side.
// ----------------------------------------------------------------------------
interface constraint_counter_pool_ctrl_if #(
   parameter int NREQ = 4,
   parameter int NCNT = 2
);
   logic                        en;
   logic [NREQ-1:0]             start;
   logic [NREQ-1:0]             inc;
   logic [NREQ-1:0]             clr;
   logic [NREQ-1:0]             owned;
   logic [NREQ-1:0]             out;
   logic [NREQ-1:0]             denied;
   logic [$clog2(NCNT+1)-1:0]   free_n;

   modport master (output en, start, inc, clr,
                   input  owned, out, denied, free_n);
   modport slave  (input  en, start, inc, clr,
                   output owned, out, denied, free_n);
endinterface

// File: rtl/constraint_counter_pool_ctrl.sv
// ----------------------------------------------------------------------------
// constraint_counter_pool_ctrl
// Shares NCNT bounded-repetition counters among NREQ {M,N} quantifier blocks.
// A requester claims a counter on start (round-robin, one grant per cycle),
// its inc pulses are counted, and out reports the range match selected by G.
// A counter returns to the pool on clr or on overflow past N.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   pool : slave modport of constraint_counter_pool_ctrl_if
// ----------------------------------------------------------------------------
module constraint_counter_pool_ctrl #(
   parameter int NREQ = 4,
   parameter int NCNT = 2,
   parameter int K    = 4,
   parameter int M    = 8,
   parameter int N    = 8,
   parameter int G    = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   constraint_counter_pool_ctrl_if.slave pool
);
   localparam int IW = $clog2(NREQ);
   localparam int FW = $clog2(NCNT + 1);
   localparam logic [K-1:0] M_K = K'(M);
   localparam logic [K-1:0] N_K = K'(N);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} cstate_e;

   cstate_e        st_q  [NCNT];
   cstate_e        st_d  [NCNT];
   logic [IW-1:0]  own_q [NCNT];
   logic [IW-1:0]  own_d [NCNT];
   logic [K-1:0]   cnt_q [NCNT];
   logic [K-1:0]   cnt_d [NCNT];
   logic [IW-1:0]  rr_q, rr_d;

   logic [NREQ-1:0] owned_v, new_start, gnt_v, out_v;
   logic [K-1:0]    req_cnt [NREQ];
   logic [FW-1:0]   idle_n;
   logic            any_idle, found;
   logic [IW-1:0]   win;

   function automatic logic [K-1:0] sat_inc(input logic [K-1:0] v);
      return (v == {K{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic in_range(input logic [K-1:0] v);
      case (G)
         0:       return (v <= N_K);
         2:       return (v >= M_K);
         default: return (v >= M_K) && (v <= N_K);
      endcase
   endfunction

   // Requester view of the registered pool: who owns what, and how many idle.
   always_comb begin
      owned_v = '0;
      idle_n  = '0;
      for (int r = 0; r < NREQ; r++) req_cnt[r] = '0;
      for (int c = 0; c < NCNT; c++) begin
         if (st_q[c] == BUSY) begin
            owned_v[own_q[c]] = 1'b1;
            req_cnt[own_q[c]] = cnt_q[c];
         end else begin
            idle_n = idle_n + FW'(1);
         end
      end
   end

   assign any_idle = (idle_n != '0);

   // Round-robin search from rr over requesters that start without owning.
   always_comb begin
      int idx;
      new_start = pool.en ? (pool.start & ~owned_v) : '0;
      found     = 1'b0;
      win       = '0;
      idx       = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!found && new_start[idx]) begin
            found = 1'b1;
            win   = IW'(idx);
         end
      end
      gnt_v = '0;
      if (found && any_idle) gnt_v[win] = 1'b1;
   end

   always_comb begin
      for (int r = 0; r < NREQ; r++) out_v[r] = owned_v[r] && in_range(req_cnt[r]);
   end

   assign pool.owned  = owned_v;
   assign pool.out    = out_v;
   assign pool.denied = new_start & ~gnt_v;
   assign pool.free_n = idle_n;

   // Next state. Grants only look at counters idle in the registered state,
   // so a counter released this cycle cannot be handed out until the next one.
   always_comb begin
      logic taken;
      taken = 1'b0;
      rr_d  = rr_q;
      for (int c = 0; c < NCNT; c++) begin
         st_d[c]  = st_q[c];
         own_d[c] = own_q[c];
         cnt_d[c] = cnt_q[c];
      end
      if (pool.en) begin
         for (int c = 0; c < NCNT; c++) begin
            if (st_q[c] == BUSY) begin
               // start > clr > inc for the owning requester
               if (pool.start[own_q[c]]) begin
                  cnt_d[c] = '0;
               end else if (pool.clr[own_q[c]]) begin
                  st_d[c]  = IDLE;
                  own_d[c] = '0;
                  cnt_d[c] = '0;
               end else if (pool.inc[own_q[c]]) begin
                  if ((G != 2) && (cnt_q[c] == N_K)) begin
                     st_d[c]  = IDLE;
                     own_d[c] = '0;
                     cnt_d[c] = '0;
                  end else begin
                     cnt_d[c] = sat_inc(cnt_q[c]);
                  end
               end
            end else if (found && !taken) begin
               st_d[c]  = BUSY;
               own_d[c] = win;
               cnt_d[c] = '0;
               taken    = 1'b1;
            end
         end
         if (found && any_idle) rr_d = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < NCNT; c++) begin
            st_q[c]  <= IDLE;
            own_q[c] <= '0;
            cnt_q[c] <= '0;
         end
         rr_q <= '0;
      end else begin
         for (int c = 0; c < NCNT; c++) begin
            st_q[c]  <= st_d[c];
            own_q[c] <= own_d[c];
            cnt_q[c] <= cnt_d[c];
         end
         rr_q <= rr_d;
      end
   end
endmodule
